wb_write_queue: RTL

Writeback buffer between the execute/load result producers and the 3-read/1-write register file. It accepts register write requests through a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It drains one entry per cycle onto the register file's single write port. It also provides three forwarding lookup ports so operand fetch sees values that are still pending in the queue.

---
 rtl/wb_write_queue.sv | 108 ++++++++++
 1 files changed

// File: rtl/wb_write_queue.sv
// Writeback queue: buffers register-file write requests in a small FIFO, drains one per cycle
// onto the single write port, and forwards pending values to three operand lookup ports.
module wb_write_queue #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  hold,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] lk_addr_1,
  input  logic [ADDR_WIDTH-1:0] lk_addr_2,
  input  logic [ADDR_WIDTH-1:0] lk_addr_3,
  output logic                  lk_hit_1,
  output logic                  lk_hit_2,
  output logic                  lk_hit_3,
  output logic [DATA_WIDTH-1:0] lk_data_1,
  output logic [DATA_WIDTH-1:0] lk_data_2,
  output logic [DATA_WIDTH-1:0] lk_data_3,
  output logic [CNT_W-1:0]      count,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_WIDTH-1:0] addr_r [DEPTH];
  logic [DATA_WIDTH-1:0] data_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  push_s;
  logic                  pop_s;
  logic [ADDR_WIDTH-1:0] lk_addr_s [3];
  logic                  lk_hit_s  [3];
  logic [DATA_WIDTH-1:0] lk_data_s [3];

  assign count    = count_r;
  assign empty    = (count_r == CNT_W'(0));
  // Ready ignores a same-cycle pop so the accept decision never depends on hold.
  assign in_ready = (count_r != CNT_W'(DEPTH));
  assign wr_en    = !empty && !hold;
  assign push_s   = in_valid && in_ready;
  assign pop_s    = wr_en;
  assign wr_addr  = empty ? {ADDR_WIDTH{1'b0}} : addr_r[rd_ptr_r];
  assign wr_data  = empty ? {DATA_WIDTH{1'b0}} : data_r[rd_ptr_r];

  assign lk_addr_s[0] = lk_addr_1;
  assign lk_addr_s[1] = lk_addr_2;
  assign lk_addr_s[2] = lk_addr_3;
  assign lk_hit_1  = lk_hit_s[0];
  assign lk_hit_2  = lk_hit_s[1];
  assign lk_hit_3  = lk_hit_s[2];
  assign lk_data_1 = lk_data_s[0];
  assign lk_data_2 = lk_data_s[1];
  assign lk_data_3 = lk_data_s[2];

  // Entry storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= {ADDR_WIDTH{1'b0}};
        data_r[i] <= {DATA_WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        addr_r[wr_ptr_r] <= in_addr;
        data_r[wr_ptr_r] <= in_data;
        wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Forwarding: walk oldest to youngest so the youngest match wins.
  always_comb begin : lookup
    logic [PTR_W-1:0] idx;
    logic             match;
    for (int p = 0; p < 3; p++) begin
      lk_hit_s[p]  = 1'b0;
      lk_data_s[p] = {DATA_WIDTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        idx          = rd_ptr_r + PTR_W'(k);
        match        = (CNT_W'(k) < count_r) && (addr_r[idx] == lk_addr_s[p]);
        lk_hit_s[p]  = lk_hit_s[p] | match;
        lk_data_s[p] = match ? data_r[idx] : lk_data_s[p];
      end
    end
  end

endmodule
